// File: rtl/rcc_bus_busy_gen.sv
`default_nettype none
// ============================================================================
//  Module      : rcc_bus_busy_gen
//  Description : Bus-bridge activity tracker for the RCC clock gating logic.
//                Counts outstanding bus transactions. It drains the bridge
//                on a low-power request, holds for a programmable number of
//                cycles after the drain, and then acknowledges that the
//                bridge clock may be stopped.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    CNT_W         width of the outstanding-transaction counter (2..8)
//    HOLD_CYC      post-drain hold length in cycles (1..15)
//  Ports
//    clk_in        bridge-side bus clock (gated bridge clock)
//    sys_rst       asynchronous active-high reset
//    txn_start     a bus transaction is presented this cycle
//    txn_done      one outstanding transaction completed this cycle
//    lp_req        low-power request (deep-sleep combination)
//    txn_stall     new transactions blocked, hold upstream
//    busy          registered busy, feeds the matching rcc_sys_clk_gen input
//    lp_ack        bridge drained, its clock may be stopped
//    outstanding   current outstanding-transaction count
//    err_overflow  sticky: start accepted while the counter was saturated
//    err_underflow sticky: done received while the count was 0
// ============================================================================
module rcc_bus_busy_gen #(
    parameter int CNT_W    = 4,
    parameter int HOLD_CYC = 3
) (
    input  logic             clk_in,
    input  logic             sys_rst,
    input  logic             txn_start,
    input  logic             txn_done,
    input  logic             lp_req,
    output logic             txn_stall,
    output logic             busy,
    output logic             lp_ack,
    output logic [CNT_W-1:0] outstanding,
    output logic             err_overflow,
    output logic             err_underflow
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_HOLD    = 2'd2,
        ST_STOPPED = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_max   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_cnt_zero  = '0;
    localparam logic [3:0]       c_hold_load = 4'(HOLD_CYC);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic [3:0]       r_timer;
    logic [3:0]       w_timer_nxt;
    logic             r_busy;
    logic             r_ovf;
    logic             r_unf;
    logic             w_ovf_set;
    logic             w_unf_set;
    logic             w_accept;
    logic             w_inc;
    logic             w_dec;

    // ------------------------------------------------------------------
    // Outstanding counter. Starts are only accepted while the bridge is
    // in RUN; a start paired with a done in the same cycle cancels out.
    // Dones are still counted in DRAIN/HOLD/STOPPED so that a stray done
    // after the drain shows up as an underflow.
    // ------------------------------------------------------------------
    assign w_accept = txn_start && (r_state == ST_RUN);
    assign w_inc    = w_accept && !txn_done;
    assign w_dec    = txn_done && !w_accept;

    always_comb begin
        w_count_nxt = r_count;
        w_ovf_set   = 1'b0;
        w_unf_set   = 1'b0;
        if (w_inc) begin
            if (r_count == c_cnt_max) begin
                w_ovf_set = 1'b1;
            end else begin
                w_count_nxt = r_count + 1'b1;
            end
        end else if (w_dec) begin
            if (r_count == c_cnt_zero) begin
                w_unf_set = 1'b1;
            end else begin
                w_count_nxt = r_count - 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Low-power sequencing: next-state and hold timer. A deasserted
    // lp_req always wins and returns the bridge to RUN. DRAIN looks at
    // the registered count, so the drain completes one cycle after the
    // last done has been counted.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = 4'd0;
        case (r_state)
            ST_RUN: begin
                if (lp_req) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!lp_req) begin
                    w_state_nxt = ST_RUN;
                end else if (r_count == c_cnt_zero) begin
                    w_state_nxt = ST_HOLD;
                    w_timer_nxt = c_hold_load;
                end
            end
            ST_HOLD: begin
                if (!lp_req) begin
                    w_state_nxt = ST_RUN;
                end else if (r_timer == 4'd1) begin
                    w_state_nxt = ST_STOPPED;
                end else begin
                    w_state_nxt = ST_HOLD;
                    w_timer_nxt = r_timer - 4'd1;
                end
            end
            ST_STOPPED: begin
                if (!lp_req) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register and datapath registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or posedge sys_rst) begin
        if (sys_rst) begin
            r_state <= ST_RUN;
            r_count <= '0;
            r_timer <= 4'd0;
            r_busy  <= 1'b0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_timer <= w_timer_nxt;
            // busy looks ahead at the next count/state so it lines up with
            // the registered outputs it summarises.
            r_busy  <= (w_count_nxt != c_cnt_zero) ||
                       (w_state_nxt == ST_DRAIN) ||
                       (w_state_nxt == ST_HOLD);
            r_ovf   <= r_ovf || w_ovf_set;
            r_unf   <= r_unf || w_unf_set;
        end
    end

    // ------------------------------------------------------------------
    // Outputs, all decoded from registered state.
    // ------------------------------------------------------------------
    assign txn_stall     = (r_state != ST_RUN);
    assign lp_ack        = (r_state == ST_STOPPED);
    assign busy          = r_busy;
    assign outstanding   = r_count;
    assign err_overflow  = r_ovf;
    assign err_underflow = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_rcc_bus_busy_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rcc_bus_busy_gen
//  Description : Directed-vector bench for rcc_bus_busy_gen. Instance a uses
//                default parameters, instance b uses CNT_W=2, HOLD_CYC=1.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rcc_bus_busy_gen;

    logic       clk_in;
    logic       sys_rst;
    logic       a_start, a_done, a_lp;
    logic       a_stall, a_busy, a_ack, a_ovf, a_unf;
    logic [3:0] a_cnt;
    logic       b_start, b_done, b_lp;
    logic       b_stall, b_busy, b_ack, b_ovf, b_unf;
    logic [1:0] b_cnt;

    int vectors;
    int miscompares;

    rcc_bus_busy_gen u_dut_a (
        .clk_in        (clk_in),
        .sys_rst       (sys_rst),
        .txn_start     (a_start),
        .txn_done      (a_done),
        .lp_req        (a_lp),
        .txn_stall     (a_stall),
        .busy          (a_busy),
        .lp_ack        (a_ack),
        .outstanding   (a_cnt),
        .err_overflow  (a_ovf),
        .err_underflow (a_unf)
    );

    rcc_bus_busy_gen #(.CNT_W(2), .HOLD_CYC(1)) u_dut_b (
        .clk_in        (clk_in),
        .sys_rst       (sys_rst),
        .txn_start     (b_start),
        .txn_done      (b_done),
        .lp_req        (b_lp),
        .txn_stall     (b_stall),
        .busy          (b_busy),
        .lp_ack        (b_ack),
        .outstanding   (b_cnt),
        .err_overflow  (b_ovf),
        .err_underflow (b_unf)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One active edge, then settle so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Packs the single-bit status of instance a: {stall, busy, ack, ovf, unf}.
    function automatic logic [31:0] a_flags();
        return {27'd0, a_stall, a_busy, a_ack, a_ovf, a_unf};
    endfunction

    initial begin
        vectors     = 0;
        miscompares = 0;
        sys_rst = 1'b1;
        a_start = 1'b0; a_done = 1'b0; a_lp = 1'b0;
        b_start = 1'b0; b_done = 1'b0; b_lp = 1'b0;
        #2;
        chk("reset_flags", a_flags(), 32'h00);
        chk("reset_cnt", a_cnt, 0);
        tick();
        tick();
        sys_rst = 1'b0;

        // Basic count: 3 starts then 3 dones.
        a_start = 1'b1;
        tick(); chk("cnt_up1", a_cnt, 1); chk("busy_up1", a_busy, 1);
        tick(); chk("cnt_up2", a_cnt, 2);
        tick(); chk("cnt_up3", a_cnt, 3);
        a_start = 1'b0; a_done = 1'b1;
        tick(); chk("cnt_dn2", a_cnt, 2);
        tick(); chk("cnt_dn1", a_cnt, 1); chk("busy_dn1", a_busy, 1);
        tick(); chk("cnt_dn0", a_cnt, 0); chk("busy_dn0", a_busy, 0);

        // Simultaneous start and done at count 5.
        a_done = 1'b0; a_start = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("cnt_five", a_cnt, 5);
        a_done = 1'b1;
        tick(); chk("cnt_simul", a_cnt, 5);
        a_start = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        a_done = 1'b0;
        chk("cnt_two", a_cnt, 2);

        // Drain and stop from count 2.
        a_lp = 1'b1;
        tick(); chk("drain_flags", a_flags(), 32'h18);
        tick();
        a_done = 1'b1; a_start = 1'b1;
        tick(); chk("drain_cnt1", a_cnt, 1);
        a_done = 1'b0; a_start = 1'b0;
        tick();
        a_done = 1'b1;
        tick(); chk("drain_cnt0", a_cnt, 0); chk("drain_busy", a_flags(), 32'h18);
        a_done = 1'b0;
        tick(); chk("hold1", a_flags(), 32'h18);
        tick(); chk("hold2", a_flags(), 32'h18);
        tick(); chk("hold3", a_flags(), 32'h18);
        tick(); chk("stopped", a_flags(), 32'h14);

        // Wake from STOPPED.
        a_lp = 1'b0;
        tick(); chk("wake", a_flags(), 32'h00);
        a_start = 1'b1;
        tick(); chk("wake_start", a_cnt, 1);
        a_start = 1'b0; a_done = 1'b1;
        tick(); chk("wake_done", a_cnt, 0);
        a_done = 1'b0;

        // Start in the lp_req cycle is still counted; then abort in HOLD.
        a_lp = 1'b1; a_start = 1'b1;
        tick(); chk("lp_start_cnt", a_cnt, 1); chk("lp_start_stall", a_stall, 1);
        a_start = 1'b0; a_done = 1'b1;
        tick(); chk("abort_cnt0", a_cnt, 0);
        a_done = 1'b0;
        tick(); chk("abort_hold3", a_flags(), 32'h18);
        tick(); chk("abort_hold2", a_flags(), 32'h18);
        a_lp = 1'b0;
        tick(); chk("abort_run", a_flags(), 32'h00);

        // Underflow at count 0.
        a_done = 1'b1;
        tick(); chk("unf_flags", a_flags(), 32'h01); chk("unf_cnt", a_cnt, 0);
        a_done = 1'b0;
        tick(); chk("unf_sticky", a_unf, 1);

        // Asynchronous reset in the middle of HOLD.
        a_lp = 1'b1;
        tick(); tick();
        chk("pre_rst_hold", a_flags(), 32'h19);
        #3;
        sys_rst = 1'b1;
        #1;
        chk("async_rst_flags", a_flags(), 32'h00);
        chk("async_rst_cnt", a_cnt, 0);
        a_lp = 1'b0;
        tick();
        sys_rst = 1'b0;
        tick();
        a_start = 1'b1;
        tick(); chk("post_rst_start", a_cnt, 1); chk("post_rst_busy", a_busy, 1);
        a_start = 1'b0;

        // Narrow counter saturation and single-cycle hold.
        b_start = 1'b1;
        tick(); tick(); tick();
        chk("sat_cnt3", b_cnt, 3); chk("sat_ovf0", b_ovf, 0);
        tick(); chk("sat_hold", b_cnt, 3); chk("sat_ovf1", b_ovf, 1);
        b_start = 1'b0; b_done = 1'b1;
        tick(); tick(); tick();
        chk("b_drained", b_cnt, 0);
        b_done = 1'b0; b_lp = 1'b1;
        tick(); chk("b_drain", b_stall, 1);
        tick(); chk("b_hold", {b_busy, b_ack}, 2'b10);
        tick(); chk("b_stopped", {b_busy, b_ack}, 2'b01);
        b_done = 1'b1;
        tick(); chk("b_stop_unf", b_unf, 1); chk("b_stop_cnt", b_cnt, 0);
        b_done = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
